// File: rtl/pipeline_ctrl_gen2_pkg.sv
// +----------------------------------------------------------------------+
// | pipeline_ctrl_gen2_pkg: shared encodings for the pipeline controller |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pipeline_ctrl_gen2_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] c_cause_none   = 3'd0;
  localparam logic [2:0] c_cause_reg    = 3'd1;
  localparam logic [2:0] c_cause_md     = 3'd2;
  localparam logic [2:0] c_cause_ifetch = 3'd3;
  localparam logic [2:0] c_cause_dmem   = 3'd4;
  localparam logic [2:0] c_cause_flush  = 3'd5;

  // Control words packed as {en_pc, en_md, en_d, en_grf}
  localparam logic [3:0] c_cw_reset = 4'b0000;
  localparam logic [3:0] c_cw_flush = 4'b1001;
  localparam logic [3:0] c_cw_dmem  = 4'b0110;
  localparam logic [3:0] c_cw_stall = 4'b0111;
  localparam logic [3:0] c_cw_run   = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_gen2_hazard_cmp.sv
// +----------------------------------------------------------------------+
// | pipeline_ctrl_gen2_hazard_cmp: one source vs. one producer hazard    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl_gen2_hazard_cmp #(
  parameter int REG_W = 5,
  parameter int T_W   = 3
) (
  input  logic             i_use,
  input  logic [REG_W-1:0] i_src,
  input  logic [T_W-1:0]   i_tuse,
  input  logic             i_wen,
  input  logic [REG_W-1:0] i_waddr,
  input  logic [T_W-1:0]   i_tnew,
  output logic             o_conflict
);

  assign o_conflict = i_use && (i_src != '0) && i_wen &&
                      (i_waddr == i_src) && (i_tnew > i_tuse);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl_gen2.sv
// +----------------------------------------------------------------------+
// | pipeline_ctrl_gen2: hazard/busy arbitration, flush sequencer, wdog   |
// | Optional perf counters: define PIPE_PERF_CNT_EN. Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl_gen2
  import pipeline_ctrl_gen2_pkg::*;
#(
  parameter int NPROD        = 3,
  parameter int REG_W        = 5,
  parameter int T_W          = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 1023,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_use_rs,
  input  logic                   d_use_rt,
  input  logic [REG_W-1:0]       d_rs,
  input  logic [REG_W-1:0]       d_rt,
  input  logic [T_W-1:0]         d_tuse_rs,
  input  logic [T_W-1:0]         d_tuse_rt,
  input  logic                   d_is_md,
  input  logic [NPROD-1:0]       prod_wen,
  input  logic [NPROD*REG_W-1:0] prod_waddr,
  input  logic [NPROD*T_W-1:0]   prod_tnew,
  input  logic                   busy_i,
  input  logic                   busy_d,
  input  logic                   busy_md,
  input  logic                   exl_req,
  output logic                   en_pc,
  output logic                   en_md,
  output logic                   en_d,
  output logic                   en_grf,
  output logic [NPROD:0]         stall_o,
  output logic [NPROD:0]         clear_o,
  output logic [2:0]             stall_cause,
  output logic                   hang_o,
  input  logic [1:0]             perf_sel,
  output logic [CNT_W-1:0]       perf_data
);

  localparam int              c_nstg       = NPROD + 1;
  localparam logic [3:0]      c_flush_load = 4'(FLUSH_CYCLES - 1);
  localparam int              c_wd_w       = $clog2(WDOG_LIMIT + 1);
  localparam logic [c_wd_w-1:0] c_wd_max   = c_wd_w'(WDOG_LIMIT);

  logic [NPROD-1:0] w_conf_rs;
  logic [NPROD-1:0] w_conf_rt;
  logic             w_wait_reg;
  logic             w_wait_md;
  logic [3:0]       w_cw;
  logic             w_stalled;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_flush_cnt;
  logic [3:0]       w_flush_cnt_nxt;
  logic [c_wd_w-1:0] r_wdog;
  logic [c_wd_w-1:0] w_wdog_nxt;
  logic             r_hang;

  for (genvar k = 0; k < NPROD; k++) begin : g_prod
    pipeline_ctrl_gen2_hazard_cmp #(.REG_W(REG_W), .T_W(T_W)) u_rs (
      .i_use      (d_use_rs),
      .i_src      (d_rs),
      .i_tuse     (d_tuse_rs),
      .i_wen      (prod_wen[k]),
      .i_waddr    (prod_waddr[k*REG_W +: REG_W]),
      .i_tnew     (prod_tnew[k*T_W +: T_W]),
      .o_conflict (w_conf_rs[k])
    );
    pipeline_ctrl_gen2_hazard_cmp #(.REG_W(REG_W), .T_W(T_W)) u_rt (
      .i_use      (d_use_rt),
      .i_src      (d_rt),
      .i_tuse     (d_tuse_rt),
      .i_wen      (prod_wen[k]),
      .i_waddr    (prod_waddr[k*REG_W +: REG_W]),
      .i_tnew     (prod_tnew[k*T_W +: T_W]),
      .o_conflict (w_conf_rt[k])
    );
  end

  assign w_wait_reg = |{w_conf_rs, w_conf_rt};
  assign w_wait_md  = busy_md && d_is_md;

  // The EXL cycle itself is the first flush cycle, so the counter tracks
  // how many flush cycles remain after the current one.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    if (exl_req) begin
      w_flush_cnt_nxt = c_flush_load;
      w_state_nxt     = (c_flush_load != 4'd0) ? ST_FLUSH : ST_RUN;
    end else if (r_state == ST_FLUSH) begin
      w_flush_cnt_nxt = r_flush_cnt - 4'd1;
      if (r_flush_cnt <= 4'd1) begin
        w_state_nxt = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_cw        = c_cw_run;
    stall_o     = '0;
    clear_o     = '0;
    stall_cause = c_cause_none;
    if (!reset) begin
      w_cw    = c_cw_reset;
      clear_o = '1;
    end else if (exl_req || (r_state == ST_FLUSH)) begin
      w_cw        = c_cw_flush;
      clear_o     = '1;
      stall_cause = c_cause_flush;
    end else if (busy_d) begin
      w_cw        = c_cw_dmem;
      stall_o     = '1;
      stall_cause = c_cause_dmem;
    end else if (w_wait_reg || w_wait_md || busy_i) begin
      w_cw    = c_cw_stall;
      stall_o = c_nstg'(1);
      clear_o = c_nstg'(2);
      if (w_wait_reg)     stall_cause = c_cause_reg;
      else if (w_wait_md) stall_cause = c_cause_md;
      else                stall_cause = c_cause_ifetch;
    end
  end

  assign {en_pc, en_md, en_d, en_grf} = w_cw;

  assign w_stalled = (stall_cause != c_cause_none) && (stall_cause != c_cause_flush);

  always_comb begin
    w_wdog_nxt = '0;
    if (w_stalled) begin
      w_wdog_nxt = (r_wdog == c_wd_max) ? r_wdog : r_wdog + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wdog <= '0;
      r_hang <= 1'b0;
    end else begin
      r_wdog <= w_wdog_nxt;
      if (w_wdog_nxt == c_wd_max) begin
        r_hang <= 1'b1;
      end
    end
  end

  assign hang_o = r_hang;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf [4];

  for (genvar i = 0; i < 4; i++) begin : g_perf
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_perf[i] <= '0;
      end else if (w_stalled && (stall_cause == 3'(i + 1))) begin
        r_perf[i] <= r_perf[i] + CNT_W'(1);
      end
    end
  end

  assign perf_data = r_perf[perf_sel];
`else
  logic w_unused_perf_sel;
  assign w_unused_perf_sel = ^perf_sel;
  assign perf_data         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl_gen2.sv
// +----------------------------------------------------------------------+
// | tb_pipeline_ctrl_gen2: directed self-checking bench with scoreboard  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_ctrl_gen2;

  localparam int NPROD = 3;
  localparam int REG_W = 5;
  localparam int T_W   = 3;
  localparam int CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   d_use_rs, d_use_rt;
  logic [REG_W-1:0]       d_rs, d_rt;
  logic [T_W-1:0]         d_tuse_rs, d_tuse_rt;
  logic                   d_is_md;
  logic [NPROD-1:0]       prod_wen;
  logic [NPROD*REG_W-1:0] prod_waddr;
  logic [NPROD*T_W-1:0]   prod_tnew;
  logic                   busy_i, busy_d, busy_md, exl_req;
  logic                   en_pc, en_md, en_d, en_grf;
  logic [NPROD:0]         stall_o, clear_o;
  logic [2:0]             stall_cause;
  logic                   hang_o;
  logic [1:0]             perf_sel;
  logic [CNT_W-1:0]       perf_data;

  pipeline_ctrl_gen2 #(
    .NPROD(NPROD), .REG_W(REG_W), .T_W(T_W),
    .FLUSH_CYCLES(3), .WDOG_LIMIT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .prod_wen(prod_wen), .prod_waddr(prod_waddr), .prod_tnew(prod_tnew),
    .busy_i(busy_i), .busy_d(busy_d), .busy_md(busy_md), .exl_req(exl_req),
    .en_pc(en_pc), .en_md(en_md), .en_d(en_d), .en_grf(en_grf),
    .stall_o(stall_o), .clear_o(clear_o), .stall_cause(stall_cause),
    .hang_o(hang_o), .perf_sel(perf_sel), .perf_data(perf_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cw;
    logic [3:0] st;
    logic [3:0] cl;
    logic [2:0] cause;
    logic       hang;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] cw, input logic [3:0] st,
                     input logic [3:0] cl, input logic [2:0] cause, input logic hang);
    exp_t e;
    exp_t p;
    exp_t o;
    e.cw = cw; e.st = st; e.cl = cl; e.cause = cause; e.hang = hang;
    sb_q.push_back(e);
    if (cause inside {3'd1, 3'd2, 3'd3, 3'd4}) exp_cnt[int'(cause) - 1]++;
    @(negedge clk);
    p = sb_q.pop_front();
    o = {en_pc, en_md, en_d, en_grf, stall_o, clear_o, stall_cause, hang_o};
    checks++;
    assert (o === p) else begin
      errors++;
      $error("FAIL %s: observed cw=%b st=%b cl=%b cause=%0d hang=%b expected cw=%b st=%b cl=%b cause=%0d hang=%b",
             tag, o.cw, o.st, o.cl, o.cause, o.hang, p.cw, p.st, p.cl, p.cause, p.hang);
    end
  endtask

  task automatic chk_perf(input string tag);
    logic [CNT_W-1:0] ev;
    for (int s = 0; s < 4; s++) begin
      perf_sel = 2'(s);
      #1;
`ifdef PIPE_PERF_CNT_EN
      ev = CNT_W'(exp_cnt[s]);
`else
      ev = '0;
`endif
      checks++;
      assert (perf_data === ev) else begin
        errors++;
        $error("FAIL %s sel%0d: observed %0d expected %0d", tag, s, perf_data, ev);
      end
    end
  endtask

  task automatic quiet();
    d_use_rs = 0; d_use_rt = 0; d_rs = '0; d_rt = '0;
    d_tuse_rs = '0; d_tuse_rt = '0; d_is_md = 0;
    prod_wen = '0; prod_waddr = '0; prod_tnew = '0;
    busy_i = 0; busy_d = 0; busy_md = 0; exl_req = 0;
  endtask

  task automatic rs_hazard_e1();
    d_use_rs = 1; d_rs = 5'd8; d_tuse_rs = 3'd0;
    prod_wen = 3'b010; prod_waddr = {5'd0, 5'd8, 5'd0}; prod_tnew = {3'd0, 3'd1, 3'd0};
  endtask

  initial begin
    reset = 0; perf_sel = 2'd0;
    for (int s = 0; s < 4; s++) exp_cnt[s] = 0;
    quiet();
    chk("reset", 4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b0);
    chk_perf("perf_reset");
    tick();
    reset = 1;
    chk("idle", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    rs_hazard_e1();
    chk("reg_haz", 4'b0111, 4'b0001, 4'b0010, 3'd1, 1'b0);
    tick();
    prod_tnew = {3'd0, 3'd0, 3'd0};
    chk("tnew0", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    rs_hazard_e1(); d_rs = 5'd0; prod_waddr = '0;
    chk("rs_zero", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    quiet();
    d_use_rt = 1; d_rt = 5'd17; d_tuse_rt = 3'd3;
    prod_wen = 3'b100; prod_waddr = {5'd17, 5'd0, 5'd0}; prod_tnew = {3'd4, 3'd0, 3'd0};
    chk("rt_haz_w", 4'b0111, 4'b0001, 4'b0010, 3'd1, 1'b0);
    tick();
    prod_tnew = {3'd3, 3'd0, 3'd0};
    chk("tnew_eq", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    quiet(); rs_hazard_e1(); busy_d = 1;
    chk("dmem_reg", 4'b0110, 4'b1111, 4'b0000, 3'd4, 1'b0);
    tick();
    quiet(); busy_md = 1; d_is_md = 1;
    chk("md", 4'b0111, 4'b0001, 4'b0010, 3'd2, 1'b0);
    tick();
    rs_hazard_e1();
    chk("reg_over_md", 4'b0111, 4'b0001, 4'b0010, 3'd1, 1'b0);
    tick();
    quiet(); busy_md = 1;
    chk("md_not_md", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    quiet(); exl_req = 1; busy_i = 1;
    chk("flush1", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    exl_req = 0;
    chk("flush2", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    chk("flush3", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    chk("after_flush", 4'b0111, 4'b0001, 4'b0010, 3'd3, 1'b0);
    tick();
    busy_i = 0;
    chk("run", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    exl_req = 1; busy_d = 1;
    chk("exl_dmem", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    exl_req = 0;
    chk("ext_c1", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    exl_req = 1;
    chk("ext_c2", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    exl_req = 0;
    chk("ext_c3", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    chk("ext_c4", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b0);
    tick();
    chk("ext_done", 4'b0110, 4'b1111, 4'b0000, 3'd4, 1'b0);
    tick();
    busy_d = 0;
    chk("run2", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    busy_i = 1;
    for (int c = 0; c < 4; c++) begin
      chk("wdog_cnt", 4'b0111, 4'b0001, 4'b0010, 3'd3, 1'b0);
      tick();
    end
    busy_i = 0;
    chk("hang_set", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b1);
    tick();
    chk("hang_hold", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b1);
    tick();
    chk_perf("perf_counts");
    exl_req = 1;
    chk("pre_abort", 4'b1001, 4'b0000, 4'b1111, 3'd5, 1'b1);
    tick();
    exl_req = 0; reset = 0;
    chk("rst_flush", 4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b1);
    tick();
    for (int s = 0; s < 4; s++) exp_cnt[s] = 0;
    reset = 1;
    chk("abort_run", 4'b1111, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick();
    chk_perf("perf_cleared");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
